// File: rtl/strobe_period_meter_if.sv
// Tick/strobe inputs and measured-period outputs of the strobe period meter.
// The master drives the tick stream and observes the measurement results.
interface strobe_period_meter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             strobe;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             overflow;

    modport master (
        output enable, strobe,
        input  period, period_valid, locked, overflow
    );

    modport slave (
        input  enable, strobe,
        output period, period_valid, locked, overflow
    );
endinterface

// File: rtl/strobe_period_meter.sv
// Recovers the enable-tick count between strobe pulses, declares lock after
// LOCK_COUNT consecutive equal periods and flags (sticky) accumulator saturation.
module strobe_period_meter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    strobe_period_meter_if.slave bus
);
    typedef enum logic [1:0] {SYNC, ACQUIRE, LOCKED} state_e;

    localparam logic [3:0] LOCK_CNT = LOCK_COUNT[3:0];
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       match_inc, match_new;
    logic             accepted;

    assign accepted  = bus.strobe && (acc_q != '0);
    assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        ovf_d     = ovf_q;
        match_d   = match_q;
        // match_q == 0 marks the first period after SYNC, which never counts as a repeat
        match_new = ((match_q != '0) && (acc_q == period_q)) ? match_inc : 4'd1;

        if (accepted) begin
            acc_d = {{(WIDTH-1){1'b0}}, bus.enable};
            unique case (state_q)
                SYNC: begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
                ACQUIRE: begin
                    period_d = acc_q;
                    valid_d  = 1'b1;
                    match_d  = match_new;
                    if (match_new >= LOCK_CNT) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
                LOCKED: begin
                    period_d = acc_q;
                    valid_d  = 1'b1;
                    match_d  = match_new;
                    if (acc_q != period_q) begin
                        locked_d = 1'b0;
                        state_d  = ACQUIRE;
                    end
                end
                default: state_d = SYNC;
            endcase
        end else if (bus.enable) begin
            if (acc_q == '1) begin
                ovf_d    = 1'b1;
                locked_d = 1'b0;
                match_d  = '0;
                state_d  = SYNC;
            end else begin
                acc_d = acc_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            acc_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
            match_q  <= match_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: doc/strobe_period_meter.md
Name: strobe_period_meter

Overview:
- Receive-side companion to the counter-with-strobe block: consumes the same `enable` tick stream and the resulting one-cycle `strobe` pulses.
- Recovers the programmed period, i.e. the number of enable ticks between strobes.
- Declares lock after LOCK_COUNT consecutive identical periods and flags tick-count overflow.
- Used to check or track a remote strobe generator and to feed measured periods back to control logic.

Parameters:
- WIDTH, 4, width of tick accumulator and reported period; max measurable period 2^WIDTH-1.
- LOCK_COUNT, 2, consecutive equal periods required to assert locked; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- enable  input  1  tick qualifier; each high cycle is one tick
- strobe  input  1  period-boundary pulse from the strobe generator
- period  output  WIDTH  last measured tick count between strobes
- period_valid  output  1  one-cycle pulse, period updated this cycle
- locked  output  1  high while the period stream is stable
- overflow  output  1  sticky, tick accumulator saturated

Behaviour:
- Reset (rst high at clk edge, overrides all):
  - acc=0, period=0, period_valid=0, locked=0, overflow=0, match_cnt=0, state=SYNC.
  - Asserting rst mid-measurement discards the partial period.
- Tick accumulator acc (WIDTH bits), non-strobe cycle:
  - acc <= acc + enable.
  - If enable=1 and acc == 2^WIDTH-1: overflow <= 1, locked <= 0, match_cnt <= 0, state <= SYNC, acc <= 2^WIDTH-1. No wrap.
- Accepted strobe (strobe=1 and acc != 0):
  - Measured value M = acc, excluding any enable in the strobe cycle itself.
  - acc <= enable (0 or 1): an enable coincident with a strobe counts toward the next period.
- Strobe with acc == 0:
  - Ignored entirely, no state change; acc <= acc + enable.
- State SYNC (after reset or overflow):
  - Accepted strobe only aligns: acc restarts per rule above, state <= ACQUIRE.
  - No period_valid.
- State ACQUIRE, accepted strobe:
  - period <= M, period_valid <= 1 on the next cycle (1-cycle registered latency).
  - If M == period (previous value), match_cnt <= match_cnt + 1 (saturating); else match_cnt <= 1.
  - First period after SYNC always sets match_cnt=1.
  - When the new match_cnt >= LOCK_COUNT: state <= LOCKED, locked <= 1 in the same cycle period_valid rises.
  - LOCK_COUNT=1 locks on the first measured period.
- State LOCKED, accepted strobe:
  - period and period_valid as above.
  - If M != previous period: locked <= 0, match_cnt <= 1, state <= ACQUIRE (same cycle as period_valid).
- Output timing:
  - period_valid is high for exactly one cycle per accepted non-SYNC strobe.
  - period holds its value between updates.
- overflow:
  - Cleared only by rst; measurement resumes normally after resync.

Test Plan:
- Default params. enable toggling 1/0, generator period 5: first strobe gives no period_valid; each later strobe gives period_valid one cycle later with period=5; locked rises with the 2nd valid period and stays high.
- Locked at period 5, generator switched to 7: next strobe gives period=7, locked falls that cycle; following strobe gives period=7 and locked=1 again.
- enable and strobe high in the same cycle, with acc=3 and 4 more enables before the next strobe: first report is 3, next report is 5.
- Enable held high for 16 ticks with no strobe (WIDTH=4): overflow=1 and locked=0 at the 16th tick, acc holds 15. Next strobe produces no period_valid; the following period of 6 reports 6 and overflow stays 1.
- Back-to-back strobes with no enable between: the second strobe is ignored, and period, period_valid and locked are unchanged.
- rst asserted mid-period while locked: next cycle all outputs are 0. The first post-reset strobe gives no period_valid; the second reports the correct period.
